frame_loader: RTL and testbench



---
 rtl/frame_pkg.sv | 24 ++
 rtl/frame_timeout_ctr.sv | 30 +++
 rtl/frame_loader.sv | 144 ++++++++++++++
 tb/tb_frame_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared frame layout constants and loader state encoding.
// Also used by the checksum stage for header length indices.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DROP,
    HANDOFF,
    WAIT_DONE
  } state_t;

  localparam int HDR_LEN      = 6;
  localparam int LEN_LO_IDX   = 4;
  localparam int LEN_HI_IDX   = 5;
  localparam int CSUM_RESERVE = 2;

  // Largest payload that still leaves room for the checksum write-back.
  function automatic logic [15:0] max_len(input int addr_bits);
    return 16'((1 << addr_bits) - HDR_LEN - CSUM_RESERVE);
  endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte idle counter for the frame loader.
// Instantiated only when FRAME_LOADER_TIMEOUT_EN is defined.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] idle;

  assign expired = run & ~kick &
                   (idle == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle <= '0;
    end else if (!run || kick || expired) begin
      idle <= '0;
    end else begin
      idle <= idle + 1'b1;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Streams one frame into the frame RAM and hands it to the checksum stage.
// Optional inter-byte timeout: define FRAME_LOADER_TIMEOUT_EN.
module frame_loader
  import frame_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_BITS  = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     mem_input,
  output logic                     mem_ready,
  input  logic                     work_complete,
  output logic [RAM_ADDR_BITS-1:0] last_addr,
  output logic                     frame_error
);

  localparam logic [15:0] MAX_L = max_len(RAM_ADDR_BITS);
  localparam logic [RAM_ADDR_BITS-1:0] LO_IDX =
    RAM_ADDR_BITS'(LEN_LO_IDX);
  localparam logic [RAM_ADDR_BITS-1:0] HI_IDX =
    RAM_ADDR_BITS'(LEN_HI_IDX);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_HDR =
    RAM_ADDR_BITS'(HDR_LEN - 1);

  state_t                   state;
  logic [RAM_ADDR_BITS-1:0] count;
  logic [RAM_ADDR_BITS-1:0] len;
  logic [RAM_ADDR_BITS-1:0] end_addr;
  logic [7:0]               len_lo;
  logic [15:0]              len_in;
  logic [15:0]              drop_cnt;
  logic                     accept;
  logic                     run_idle;
  logic                     timeout_hit;

  assign accept   = in_valid & in_ready;
  assign len_in   = {in_data, len_lo};
  assign end_addr = LAST_HDR + len;
  assign run_idle = (state == HEADER) ||
                    (state == PAYLOAD) ||
                    (state == DROP);

`ifdef FRAME_LOADER_TIMEOUT_EN
  frame_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .run    (run_idle),
    .kick   (accept),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, run_idle};
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      mem_input    <= '0;
      mem_ready    <= 1'b0;
      last_addr    <= '0;
      frame_error  <= 1'b0;
      count        <= '0;
      len          <= '0;
      len_lo       <= '0;
      drop_cnt     <= '0;
    end else begin
      write_enable <= 1'b0;
      frame_error  <= 1'b0;
      if (accept && state != DROP) begin
        write_enable <= 1'b1;
        address      <= count;
        mem_input    <= RAM_WIDTH'(in_data);
        count        <= count + 1'b1;
      end
      if (timeout_hit) begin
        frame_error <= 1'b1;
        state       <= IDLE;
        count       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            in_ready <= 1'b1;
            if (accept) state <= HEADER;
          end
          HEADER: if (accept) begin
            if (count == LO_IDX) len_lo <= in_data;
            if (count == HI_IDX) begin
              if (len_in > MAX_L) begin
                state    <= DROP;
                drop_cnt <= len_in;
              end else if (len_in == 16'd0) begin
                state    <= HANDOFF;
                in_ready <= 1'b0;
                len      <= '0;
              end else begin
                state <= PAYLOAD;
                len   <= len_in[RAM_ADDR_BITS-1:0];
              end
            end
          end
          PAYLOAD: if (accept && count == end_addr) begin
            state    <= HANDOFF;
            in_ready <= 1'b0;
          end
          DROP: if (accept) begin
            drop_cnt <= drop_cnt - 16'd1;
            if (drop_cnt == 16'd1) begin
              frame_error <= 1'b1;
              state       <= IDLE;
              count       <= '0;
            end
          end
          HANDOFF: begin
            mem_ready <= 1'b1;
            last_addr <= end_addr;
            state     <= WAIT_DONE;
          end
          WAIT_DONE: if (work_complete) begin
            mem_ready <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader.
// Timeout scenario runs only when FRAME_LOADER_TIMEOUT_EN is defined.
module tb_frame_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       write_enable;
  logic [9:0] address;
  logic [7:0] mem_input;
  logic       mem_ready;
  logic       work_complete = 1'b0;
  logic [9:0] last_addr;
  logic       frame_error;

  int tests = 0;
  int fails = 0;

  int wa[$];
  int wd[$];
  int wc[$];
  int cyc = 0;
  int err_pulses = 0;
  int mr_rises = 0;
  logic mr_q = 1'b0;

  frame_loader #(
    .RAM_WIDTH(8),
    .RAM_ADDR_BITS(10),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .write_enable(write_enable),
    .address(address),
    .mem_input(mem_input),
    .mem_ready(mem_ready),
    .work_complete(work_complete),
    .last_addr(last_addr),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (write_enable) begin
      wa.push_back(int'(address));
      wd.push_back(int'(mem_input));
      wc.push_back(cyc);
    end
    if (frame_error) err_pulses = err_pulses + 1;
    if (mem_ready && !mr_q) mr_rises = mr_rises + 1;
    mr_q = mem_ready;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    err_pulses = 0;
    mr_rises = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clock);
  endtask

  task automatic release_ram();
    work_complete = 1'b1;
    @(negedge clock);
    work_complete = 1'b0;
    chk("wc_mem_ready", 32'(mem_ready), 32'd0);
    chk("wc_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [7:0] t1[9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h03,
                        8'h00, 8'hA0, 8'hB0, 8'hC0};
  logic [7:0] t4[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
                         8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
  logic [7:0] t5[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                        8'h00, 8'h55};

  initial begin
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_data", 32'(mem_input), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_last", 32'(last_addr), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: L=3 streamed back to back
    clear_log();
    for (int i = 0; i < 9; i++) send(t1[i], 0);
    in_valid = 1'b0;
    chk("t1_mr_early", 32'(mem_ready), 32'd0);
    @(negedge clock);
    chk("t1_mr", 32'(mem_ready), 32'd1);
    chk("t1_last", 32'(last_addr), 32'd8);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("t1_hold_mr", 32'(mem_ready), 32'd1);
    chk("t1_hold_ir", 32'(in_ready), 32'd0);
    chk("t1_nwr", 32'(wa.size()), 32'd9);
    for (int i = 0; i < 9 && i < wa.size(); i++) begin
      chk($sformatf("t1_a%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("t1_d%0d", i), 32'(wd[i]), 32'(t1[i]));
      chk($sformatf("t1_c%0d", i), 32'(wc[i]), 32'(wc[0] + i));
    end
    release_ram();

    // 2: L=0 header-only frame
    clear_log();
    for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), 0);
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t2_mr", 32'(mem_ready), 32'd1);
    chk("t2_last", 32'(last_addr), 32'd5);
    @(negedge clock);
    chk("t2_nwr", 32'(wa.size()), 32'd6);
    release_ram();

    // 3: L=1017 exceeds capacity, frame dropped
    clear_log();
    for (int i = 0; i < 4; i++) send(8'(i), 0);
    send(8'hF9, 0);
    send(8'h03, 0);
    for (int i = 0; i < 1017; i++) send(8'(i), 0);
    in_valid = 1'b0;
    chk("t3_ferr", 32'(frame_error), 32'd1);
    @(negedge clock);
    chk("t3_ferr_end", 32'(frame_error), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    chk("t3_nwr", 32'(wa.size()), 32'd6);
    chk("t3_pulses", 32'(err_pulses), 32'd1);
    chk("t3_no_mr", 32'(mr_rises), 32'd0);

    // 4: L=4 with random valid gaps
    clear_log();
    for (int i = 0; i < 10; i++) send(t4[i], $urandom_range(0, 3));
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("t4_mr", 32'(mem_ready), 32'd1);
    chk("t4_last", 32'(last_addr), 32'd9);
    chk("t4_nwr", 32'(wa.size()), 32'd10);
    for (int i = 0; i < 10 && i < wa.size(); i++) begin
      chk($sformatf("t4_a%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("t4_d%0d", i), 32'(wd[i]), 32'(t4[i]));
    end
    release_ram();

    // 5: reset mid payload, then a fresh L=1 frame
    clear_log();
    for (int i = 0; i < 4; i++) send(8'h10, 0);
    send(8'h0A, 0);
    send(8'h00, 0);
    for (int i = 0; i < 3; i++) send(8'h77, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_we", 32'(write_enable), 32'd0);
    chk("t5_addr", 32'(address), 32'd0);
    chk("t5_data", 32'(mem_input), 32'd0);
    chk("t5_mr", 32'(mem_ready), 32'd0);
    chk("t5_last", 32'(last_addr), 32'd0);
    chk("t5_ferr", 32'(frame_error), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    clear_log();
    for (int i = 0; i < 7; i++) send(t5[i], 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("t5_mr_new", 32'(mem_ready), 32'd1);
    chk("t5_last_new", 32'(last_addr), 32'd6);
    chk("t5_nwr", 32'(wa.size()), 32'd7);
    for (int i = 0; i < 7 && i < wa.size(); i++) begin
      chk($sformatf("t5_a%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("t5_d%0d", i), 32'(wd[i]), 32'(t5[i]));
    end
    release_ram();

`ifdef FRAME_LOADER_TIMEOUT_EN
    // 6: stall after 7 bytes of an L=5 frame
    clear_log();
    for (int i = 0; i < 4; i++) send(8'h20, 0);
    send(8'h05, 0);
    send(8'h00, 0);
    send(8'h99, 0);
    in_valid = 1'b0;
    repeat (15) @(negedge clock);
    chk("t6_ferr_early", 32'(frame_error), 32'd0);
    @(negedge clock);
    chk("t6_ferr", 32'(frame_error), 32'd1);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_mr", 32'(mem_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("t6_pulses", 32'(err_pulses), 32'd1);
    chk("t6_no_mr", 32'(mr_rises), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
